// File: rtl/color_sched_pkg.sv
// Shared colour codes, scheduler state encoding and the RGB result decoder
// for the colour-scan scheduler.
package color_sched_pkg;

   typedef enum logic [1:0] {
      COLOR_NONE  = 2'd0,
      COLOR_RED   = 2'd1,
      COLOR_GREEN = 2'd2,
      COLOR_BLUE  = 2'd3
   } color_e;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_RST_SENSOR  = 3'd1,
      ST_GO          = 3'd2,
      ST_WAIT_DONE   = 3'd3,
      ST_EVAL        = 3'd4,
      ST_WAIT_PERIOD = 3'd5
   } state_e;

   // rgb is {red, green, blue}; anything other than exactly one bit set is no colour
   function automatic color_e decode_rgb(input logic [2:0] rgb);
      case (rgb)
         3'b100:  decode_rgb = COLOR_RED;
         3'b010:  decode_rgb = COLOR_GREEN;
         3'b001:  decode_rgb = COLOR_BLUE;
         default: decode_rgb = COLOR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/color_agree_filter.sv
// Debounce filter: the reported colour only moves after AGREE_COUNT
// consecutive identical non-zero samples; a timeout invalidates it.
module color_agree_filter
   import color_sched_pkg::*;
#(
   parameter int AGREE_COUNT = 3
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   sample_stb_i,
   input  color_e sample_i,
   input  logic   timeout_stb_i,
   output color_e color_o,
   output logic   color_valid_o,
   output logic   color_changed_o
);

   localparam logic [3:0] AGREE = 4'(AGREE_COUNT);

   color_e     cand_q, cand_d;
   color_e     color_q, color_d;
   logic [3:0] streak_q, streak_d;
   logic       valid_q, valid_d;
   logic       changed_q, changed_d;

   always_comb begin
      cand_d    = cand_q;
      color_d   = color_q;
      streak_d  = streak_q;
      valid_d   = valid_q;
      changed_d = 1'b0;
      if (sample_stb_i) begin
         if (sample_i == COLOR_NONE) begin
            streak_d = '0;
         end else if (sample_i == cand_q) begin
            streak_d = (streak_q >= AGREE) ? AGREE : streak_q + 4'd1;
         end else begin
            cand_d   = sample_i;
            streak_d = 4'd1;
         end
         if ((streak_d == AGREE) && ((color_q != cand_d) || !valid_q)) begin
            color_d   = cand_d;
            valid_d   = 1'b1;
            changed_d = 1'b1;
         end
      end else if (timeout_stb_i) begin
         // colour and candidate survive a timeout; only the evidence is discarded
         streak_d = '0;
         if (valid_q) begin
            valid_d   = 1'b0;
            changed_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q    <= COLOR_NONE;
         color_q   <= COLOR_NONE;
         streak_q  <= '0;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         cand_q    <= cand_d;
         color_q   <= color_d;
         streak_q  <= streak_d;
         valid_q   <= valid_d;
         changed_q <= changed_d;
      end
   end

   assign color_o         = color_q;
   assign color_valid_o   = valid_q;
   assign color_changed_o = changed_q;

endmodule

// File: rtl/color_scan_scheduler.sv
// Periodic colour-sensor scan sequencer with done timeout and debounced result.
// Define COLOR_SCAN_STATS_EN to add saturating scan_count / timeout_count outputs.
module color_scan_scheduler
   import color_sched_pkg::*;
#(
   parameter int PERIOD_CYCLES  = 1000000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int AGREE_COUNT    = 3,
   parameter int CNT_W          = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       err_clr,
   input  logic       sensor_done,
   input  logic       sensor_red,
   input  logic       sensor_green,
   input  logic       sensor_blue,
   output logic       sensor_rst,
   output logic       sensor_go,
   output logic [1:0] color,
   output logic       color_valid,
   output logic       color_changed,
   output logic       timeout_err,
   output logic       busy
`ifdef COLOR_SCAN_STATS_EN
   ,
   output logic [15:0] scan_count,
   output logic [15:0] timeout_count
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       rgb_q, rgb_d;
   logic             terr_q, terr_d;
   logic             rst_q, go_q, busy_q;
   logic             sample_stb, timeout_stb;
   color_e           color_f;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rgb_d       = rgb_q;
      terr_d      = terr_q;
      sample_stb  = 1'b0;
      timeout_stb = 1'b0;
      if (err_clr) terr_d = 1'b0;
      case (state_q)
         ST_IDLE:       if (enable) state_d = ST_RST_SENSOR;
         ST_RST_SENSOR: state_d = ST_GO;
         ST_GO: begin
            cnt_d   = '0;
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            cnt_d = cnt_q + CNT_ONE;
            // on the first cycle done may still be the previous scan's result
            if (sensor_done && (cnt_q != '0)) begin
               rgb_d   = {sensor_red, sensor_green, sensor_blue};
               state_d = ST_EVAL;
            end else if (cnt_q == TIMEOUT_LAST) begin
               terr_d      = 1'b1;
               timeout_stb = 1'b1;
               cnt_d       = '0;
               state_d     = ST_WAIT_PERIOD;
            end
         end
         ST_EVAL: begin
            sample_stb = 1'b1;
            cnt_d      = '0;
            state_d    = ST_WAIT_PERIOD;
         end
         ST_WAIT_PERIOD: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == PERIOD_LAST) state_d = enable ? ST_RST_SENSOR : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // outputs are decoded from the next state so they line up with the state itself
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rgb_q   <= '0;
         terr_q  <= 1'b0;
         rst_q   <= 1'b0;
         go_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rgb_q   <= rgb_d;
         terr_q  <= terr_d;
         rst_q   <= (state_d == ST_RST_SENSOR);
         go_q    <= (state_d == ST_GO);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   color_agree_filter #(
      .AGREE_COUNT(AGREE_COUNT)
   ) u_filter (
      .clk            (clk),
      .rst_n          (reset),
      .sample_stb_i   (sample_stb),
      .sample_i       (decode_rgb(rgb_q)),
      .timeout_stb_i  (timeout_stb),
      .color_o        (color_f),
      .color_valid_o  (color_valid),
      .color_changed_o(color_changed)
   );

   assign sensor_rst  = rst_q;
   assign sensor_go   = go_q;
   assign timeout_err = terr_q;
   assign busy        = busy_q;
   assign color       = color_f;

`ifdef COLOR_SCAN_STATS_EN
   logic [15:0] scan_cnt_q, to_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt_q <= '0;
         to_cnt_q   <= '0;
      end else begin
         if (sample_stb && (scan_cnt_q != 16'hFFFF)) scan_cnt_q <= scan_cnt_q + 16'd1;
         if (timeout_stb && (to_cnt_q != 16'hFFFF))  to_cnt_q   <= to_cnt_q + 16'd1;
      end
   end

   assign scan_count    = scan_cnt_q;
   assign timeout_count = to_cnt_q;
`endif

endmodule
